// File: rtl/lzc_norm_sched_pkg.sv
// ----------------------------------------------------------------------------
// lzc_norm_sched_pkg
//   Shared constants and the round-robin pick helper for the LZC/normalize
//   scheduler.
//   MANT_W  : mantissa width handled by the shared datapath
//   SHIFT_W : width of the leading-zero count
//   MAX_REQ : widest requester vector rr_pick can arbitrate
// ----------------------------------------------------------------------------
package lzc_norm_sched_pkg;

   localparam int MANT_W  = 24;
   localparam int SHIFT_W = 5;
   localparam int MAX_REQ = 8;

   // One-hot grant for the first valid requester found when searching
   // ptr, ptr+1, ... modulo nreq. Returns zero when nothing is valid.
   function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                                  input logic [2:0]         ptr,
                                                  input int                 nreq);
      logic [MAX_REQ-1:0] grant;
      logic               found;
      logic [2:0]         idx;
      grant = {MAX_REQ{1'b0}};
      found = 1'b0;
      for (int k = 0; k < MAX_REQ; k++) begin
         idx = 3'((int'(ptr) + k) % nreq);
         if ((k < nreq) && !found && valid[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
         end
      end
      return grant;
   endfunction

endpackage

// File: rtl/lzc24_norm.sv
// ----------------------------------------------------------------------------
// lzc24_norm
//   Combinational 24-bit leading-zero count with barrel left shift.
//   i_mant  : mantissa to normalize
//   o_norm  : i_mant shifted left by o_shift (MSB set unless o_zero)
//   o_shift : number of leading zeros, 0..23 (0 for an all-zero input)
//   o_zero  : i_mant is all zero
// ----------------------------------------------------------------------------
module lzc24_norm
   import lzc_norm_sched_pkg::*;
(
   input  logic [MANT_W-1:0]  i_mant,
   output logic [MANT_W-1:0]  o_norm,
   output logic [SHIFT_W-1:0] o_shift,
   output logic               o_zero
);

   logic [SHIFT_W-1:0] w_lzc;

   // Leading-zero count: scanning upward, the highest set bit is the last writer.
   always_comb begin
      w_lzc = {SHIFT_W{1'b0}};
      for (int i = 0; i < MANT_W; i++) begin
         if (i_mant[i]) begin
            w_lzc = SHIFT_W'(MANT_W - 1 - i);
         end else begin
            w_lzc = w_lzc;
         end
      end
   end

   // An all-zero input leaves w_lzc at 0, so o_norm is 0 with no extra muxing.
   assign o_zero  = (i_mant == {MANT_W{1'b0}});
   assign o_shift = w_lzc;
   assign o_norm  = i_mant << w_lzc;

endmodule

// File: rtl/lzc_norm_sched.sv
// ----------------------------------------------------------------------------
// lzc_norm_sched
//   Round-robin scheduler sharing one LZC/normalize datapath among NREQ
//   requesters through a 2-stage pipeline (operand capture, LZC+shift).
//   CLK, RESET          : clock, asynchronous active-high reset
//   flush               : synchronous pipeline clear
//   req_valid/req_mant  : per-requester request, mantissa i at [24*i+23:24*i]
//   req_ready           : per-requester accept, one-hot or zero
//   rsp_valid/rsp_ready : backpressured response handshake
//   rsp_id/norm/shift/zero : requester index, normalized mantissa, LZC, zero flag
//   busy                : either pipeline stage occupied
// ----------------------------------------------------------------------------
module lzc_norm_sched
   import lzc_norm_sched_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IDW  = 2
)(
   input  logic                   CLK,
   input  logic                   RESET,
   input  logic                   flush,
   input  logic [NREQ-1:0]        req_valid,
   input  logic [MANT_W*NREQ-1:0] req_mant,
   output logic [NREQ-1:0]        req_ready,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [IDW-1:0]         rsp_id,
   output logic [MANT_W-1:0]      rsp_norm,
   output logic [SHIFT_W-1:0]     rsp_shift,
   output logic                   rsp_zero,
   output logic                   busy
);

   logic [IDW-1:0]     r_rr_ptr;
   logic               r_s1_vld;
   logic [IDW-1:0]     r_s1_id;
   logic [MANT_W-1:0]  r_s1_mant;
   logic               r_s2_vld;
   logic [IDW-1:0]     r_s2_id;
   logic [MANT_W-1:0]  r_s2_norm;
   logic [SHIFT_W-1:0] r_s2_shift;
   logic               r_s2_zero;

   logic               w_s2_adv;
   logic               w_s1_adv;
   logic [NREQ-1:0]    w_grant;
   logic [IDW-1:0]     w_grant_idx;
   logic [MANT_W-1:0]  w_sel_mant;
   logic [IDW-1:0]     w_ptr_nxt;
   logic               w_hs;
   logic [MANT_W-1:0]  w_norm;
   logic [SHIFT_W-1:0] w_shift;
   logic               w_zero;

   // A stage may load when it is empty or its content moves on this edge.
   assign w_s2_adv = ~r_s2_vld | rsp_ready;
   assign w_s1_adv = ~r_s1_vld | w_s2_adv;

   assign w_grant   = NREQ'(rr_pick(MAX_REQ'(req_valid), 3'(r_rr_ptr), NREQ));
   // RESET also masks req_ready so no requester sees an accept while in reset.
   assign req_ready = w_grant & {NREQ{w_s1_adv & ~flush & ~RESET}};
   assign w_hs      = |req_ready;

   // Encode the one-hot grant and select the winning mantissa (AND-OR mux).
   always_comb begin
      w_grant_idx = {IDW{1'b0}};
      w_sel_mant  = {MANT_W{1'b0}};
      for (int i = 0; i < NREQ; i++) begin
         w_grant_idx = w_grant_idx | (w_grant[i] ? IDW'(i) : {IDW{1'b0}});
         w_sel_mant  = w_sel_mant | (req_mant[i*MANT_W +: MANT_W] & {MANT_W{w_grant[i]}});
      end
   end

   assign w_ptr_nxt = (w_grant_idx == IDW'(NREQ - 1)) ? {IDW{1'b0}} : (w_grant_idx + IDW'(1));

   // Round-robin pointer: moves just past the winner on every accepted request.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_rr_ptr <= {IDW{1'b0}};
      end else if (w_hs) begin
         r_rr_ptr <= w_ptr_nxt;
      end else begin
         r_rr_ptr <= r_rr_ptr;
      end
   end

   // Stage 1: capture the granted requester's id and mantissa.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_s1_vld  <= 1'b0;
         r_s1_id   <= {IDW{1'b0}};
         r_s1_mant <= {MANT_W{1'b0}};
      end else if (flush) begin
         r_s1_vld  <= 1'b0;
      end else if (w_s1_adv) begin
         r_s1_vld  <= w_hs;
         if (w_hs) begin
            r_s1_id   <= w_grant_idx;
            r_s1_mant <= w_sel_mant;
         end
      end
   end

   lzc24_norm u_lzc (
      .i_mant  (r_s1_mant),
      .o_norm  (w_norm),
      .o_shift (w_shift),
      .o_zero  (w_zero)
   );

   // Stage 2: register the normalized result; holds while the consumer stalls.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_s2_vld   <= 1'b0;
         r_s2_id    <= {IDW{1'b0}};
         r_s2_norm  <= {MANT_W{1'b0}};
         r_s2_shift <= {SHIFT_W{1'b0}};
         r_s2_zero  <= 1'b0;
      end else if (flush) begin
         r_s2_vld   <= 1'b0;
      end else if (w_s2_adv) begin
         r_s2_vld   <= r_s1_vld;
         if (r_s1_vld) begin
            r_s2_id    <= r_s1_id;
            r_s2_norm  <= w_norm;
            r_s2_shift <= w_shift;
            r_s2_zero  <= w_zero;
         end
      end
   end

   assign rsp_valid = r_s2_vld;
   assign rsp_id    = r_s2_id;
   assign rsp_norm  = r_s2_norm;
   assign rsp_shift = r_s2_shift;
   assign rsp_zero  = r_s2_zero;
   assign busy      = r_s1_vld | r_s2_vld;

endmodule

// File: tb/tb_lzc_norm_sched.sv
module tb_lzc_norm_sched;

   localparam int N  = 4;
   localparam int IW = 2;

   logic            CLK = 1'b0;
   logic            RESET;
   logic            flush;
   logic [N-1:0]    req_valid;
   logic [24*N-1:0] req_mant;
   logic [N-1:0]    req_ready;
   logic            rsp_valid;
   logic            rsp_ready;
   logic [IW-1:0]   rsp_id;
   logic [23:0]     rsp_norm;
   logic [4:0]      rsp_shift;
   logic            rsp_zero;
   logic            busy;

   always #5 CLK = ~CLK;

   lzc_norm_sched #(.NREQ(N), .IDW(IW)) dut (
      .CLK       (CLK),
      .RESET     (RESET),
      .flush     (flush),
      .req_valid (req_valid),
      .req_mant  (req_mant),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_norm  (rsp_norm),
      .rsp_shift (rsp_shift),
      .rsp_zero  (rsp_zero),
      .busy      (busy)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [IW-1:0] id;
      logic [23:0]   norm;
      int            shift;
      bit            zero;
      int            stage;   // 1 = operand captured, 2 = result presented
   } item_t;

   item_t q[$];
   int    m_ptr = 0;

   // Normalize by repeated doubling until the MSB is set.
   function automatic void ref_norm(input logic [23:0] m, output logic [23:0] n,
                                    output int s, output bit z);
      n = m;
      s = 0;
      z = (m == 24'd0);
      if (!z) begin
         while (n[23] == 1'b0) begin
            n = n << 1;
            s++;
         end
      end
   endfunction

   function automatic logic [N-1:0] model_grant();
      logic [N-1:0] g;
      g = '0;
      if (flush || (q.size() == 2 && !rsp_ready)) return g;
      for (int k = 0; k < N; k++) begin
         int i;
         i = (m_ptr + k) % N;
         if (req_valid[i]) begin
            g[i] = 1'b1;
            return g;
         end
      end
      return g;
   endfunction

   task automatic check_outputs();
      bit ev;
      ev = (q.size() > 0) && (q[0].stage == 2);
      chk("rsp_valid", 32'(rsp_valid), 32'(ev));
      chk("busy", 32'(busy), 32'(q.size() > 0));
      if (ev) begin
         chk("rsp_id", 32'(rsp_id), 32'(q[0].id));
         chk("rsp_norm", 32'(rsp_norm), 32'(q[0].norm));
         chk("rsp_shift", 32'(rsp_shift), 32'(q[0].shift));
         chk("rsp_zero", 32'(rsp_zero), 32'(q[0].zero));
      end
   endtask

   // One clock: check predicted accept, advance the edge, update model, check outputs.
   task automatic step();
      logic [N-1:0] g;
      int           gi;
      bit           s2_has;
      item_t        it;
      logic [23:0]  nn;
      int           ss;
      bit           zz;
      g = model_grant();
      #1;
      chk("req_ready", 32'(req_ready), 32'(g));
      @(posedge CLK);
      if (flush) begin
         q.delete();
      end else begin
         if (q.size() > 0 && q[0].stage == 2 && rsp_ready) q.delete(0);
         s2_has = 1'b0;
         foreach (q[j]) if (q[j].stage == 2) s2_has = 1'b1;
         foreach (q[j]) if (q[j].stage == 1 && !s2_has) q[j].stage = 2;
         if (g != '0) begin
            gi = 0;
            for (int i = 0; i < N; i++) if (g[i]) gi = i;
            ref_norm(req_mant[24*gi +: 24], nn, ss, zz);
            it.id = IW'(gi);
            it.norm = nn;
            it.shift = ss;
            it.zero = zz;
            it.stage = 1;
            q.push_back(it);
            m_ptr = (gi + 1) % N;
         end
      end
      #1;
      check_outputs();
   endtask

   task automatic do_reset();
      RESET = 1'b1;
      #1;
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_rsp_id", 32'(rsp_id), 32'd0);
      chk("rst_rsp_norm", 32'(rsp_norm), 32'd0);
      chk("rst_rsp_shift", 32'(rsp_shift), 32'd0);
      chk("rst_rsp_zero", 32'(rsp_zero), 32'd0);
      q.delete();
      m_ptr = 0;
      @(posedge CLK);
      #1;
      RESET = 1'b0;
   endtask

   typedef struct {
      int          id;
      logic [23:0] mant;
      logic [23:0] norm;
      int          shift;
      bit          zero;
   } vec_t;

   vec_t tbl[8];
   int   acc;

   initial begin
      flush = 1'b0;
      rsp_ready = 1'b1;
      req_valid = '0;
      req_mant = '0;
      do_reset();

      // ---- single-request table ----
      tbl[0] = '{0, 24'h00_1234, 24'h91_A000, 11, 1'b0};
      tbl[1] = '{1, 24'h00_0000, 24'h00_0000,  0, 1'b1};
      tbl[2] = '{2, 24'h80_0000, 24'h80_0000,  0, 1'b0};
      tbl[3] = '{3, 24'h00_0001, 24'h80_0000, 23, 1'b0};
      tbl[4] = '{0, 24'h40_0000, 24'h80_0000,  1, 1'b0};
      tbl[5] = '{1, 24'h00_0F00, 24'hF0_0000, 12, 1'b0};
      tbl[6] = '{2, 24'hFF_FFFF, 24'hFF_FFFF,  0, 1'b0};
      tbl[7] = '{3, 24'h0A_BCDE, 24'hAB_CDE0,  4, 1'b0};
      for (int v = 0; v < 8; v++) begin
         req_valid = 4'b0001 << tbl[v].id;
         req_mant = '0;
         req_mant[24*tbl[v].id +: 24] = tbl[v].mant;
         step();
         req_valid = '0;
         step();
         chk("tbl_valid", 32'(rsp_valid), 32'd1);
         chk("tbl_id", 32'(rsp_id), 32'(tbl[v].id));
         chk("tbl_norm", 32'(rsp_norm), 32'(tbl[v].norm));
         chk("tbl_shift", 32'(rsp_shift), 32'(tbl[v].shift));
         chk("tbl_zero", 32'(rsp_zero), 32'(tbl[v].zero));
      end
      step();

      // ---- stream, then reset mid-stream; fairness from req0 afterwards ----
      req_valid = 4'hF;
      for (int i = 0; i < N; i++) req_mant[24*i +: 24] = 24'($urandom) >> $urandom_range(0, 24);
      repeat (3) step();
      do_reset();
      #1;
      chk("first_grant_after_reset", 32'(req_ready), 32'b0001);
      step();
      for (int k = 0; k < 8; k++) begin
         step();
         chk("fair_valid", 32'(rsp_valid), 32'd1);
         chk("fair_id", 32'(rsp_id), 32'(k % N));
      end

      // ---- backpressure: drain, then stall 6 cycles with requests pending ----
      req_valid = '0;
      repeat (2) step();
      rsp_ready = 1'b0;
      req_valid = 4'hF;
      for (int i = 0; i < N; i++) req_mant[24*i +: 24] = 24'($urandom) >> $urandom_range(0, 24);
      acc = 0;
      for (int k = 0; k < 6; k++) begin
         #1;
         if (req_ready != '0) acc++;
         step();
      end
      chk("bp_accepts", 32'(acc), 32'd2);
      rsp_ready = 1'b1;
      req_valid = '0;
      repeat (3) step();
      chk("bp_drained", 32'(busy), 32'd0);

      // ---- flush with both stages full ----
      rsp_ready = 1'b0;
      req_valid = 4'hF;
      repeat (3) step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("flush_busy", 32'(busy), 32'd0);
      chk("flush_rsp_valid", 32'(rsp_valid), 32'd0);

      // ---- randomized traffic against the model ----
      for (int k = 0; k < 400; k++) begin
         req_valid = N'($urandom);
         for (int i = 0; i < N; i++) req_mant[24*i +: 24] = 24'($urandom) >> $urandom_range(0, 24);
         rsp_ready = ($urandom_range(0, 3) != 0);
         flush = ($urandom_range(0, 30) == 0);
         step();
      end
      flush = 1'b0;
      req_valid = '0;
      rsp_ready = 1'b1;
      repeat (3) step();
      chk("final_idle", 32'(busy), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
